// File: rtl/gf180mcu_osu_sc_gp9t3v3__rrarb2_1.sv
// ---------------------------------------------------------------------------
// gf180mcu_osu_sc_gp9t3v3__rrarb2_1
//
// Two-requester round-robin arbiter cell. It produces break-before-make
// one-hot selects for an AOI22 inverting 2:1 mux: GNT0 drives the A1 leg and
// GNT1 drives the B1 leg. The two legs are never active together, and a
// handover between owners always passes through one dead (TURN) cycle.
//
// Parameters
//   HOLD_MAX  maximum consecutive grant cycles while the other side waits
//             (legal range 1..7)
//
// Ports
//   CLK   in   rising-edge clock
//   RN    in   asynchronous active-low reset
//   REQ0  in   request from source 0
//   REQ1  in   request from source 1
//   LOCK  in   while high, the current owner cannot be preempted by tenure
//   GNT0  out  registered select for the AOI22 A1 leg
//   GNT1  out  registered select for the AOI22 B1 leg
//   BUSY  out  registered, GNT0 | GNT1
//
// Timing view: define GF180_TIMING to enable the zero-delay specify block.
// A timing-check notifier then forces the outputs to X until the next reset.
// ---------------------------------------------------------------------------
module gf180mcu_osu_sc_gp9t3v3__rrarb2_1 #(
    parameter int HOLD_MAX = 4
) (
    input  logic CLK,
    input  logic RN,
    input  logic REQ0,
    input  logic REQ1,
    input  logic LOCK,
    output logic GNT0,
    output logic GNT1,
    output logic BUSY
);

    typedef enum logic [1:0] {IDLE, G0, G1, TURN} state_t;

    // Tenure limit, expressed as the counter value on the last held cycle.
    localparam logic [2:0] HOLD_LIM = 3'(HOLD_MAX - 1);

    state_t     state, nxt_state;
    logic [2:0] cnt, nxt_cnt;
    logic       last, nxt_last;  // last owner: 0 = source 0, 1 = source 1
    logic       run;             // first edge after RN release only arms this
    logic       poison;          // last sampling edge saw X/Z on an input
    logic       gnt0_q, gnt1_q, busy_q;
    logic       viol;            // timing-check violation seen
    logic       in_x;
    logic       req_own, req_oth;

    assign in_x    = $isunknown({REQ0, REQ1, LOCK});
    assign req_own = (state == G1) ? REQ1 : REQ0;
    assign req_oth = (state == G1) ? REQ0 : REQ1;

    // Next-state arbitration. IDLE and TURN share the same decision; in TURN
    // LAST still names the previous owner, so a waiting requester wins.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_last  = last;
        case (state)
            IDLE, TURN: begin
                nxt_state = IDLE;
                if (REQ0 && (!REQ1 || last)) begin
                    nxt_state = G0;
                    nxt_cnt   = 3'd0;
                    nxt_last  = 1'b0;
                end else if (REQ1) begin
                    nxt_state = G1;
                    nxt_cnt   = 3'd0;
                    nxt_last  = 1'b1;
                end
            end
            G0, G1: begin
                if (!req_own) begin
                    nxt_state = req_oth ? TURN : IDLE;
                end else if (req_oth && !LOCK && (cnt >= HOLD_LIM)) begin
                    // >= so that dropping LOCK after a long locked tenure
                    // preempts on the very next edge.
                    nxt_state = TURN;
                end else if (cnt != 3'd7) begin
                    nxt_cnt = cnt + 3'd1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state  <= IDLE;
            cnt    <= 3'd0;
            last   <= 1'b1;  // source 0 wins the first tie
            run    <= 1'b0;
            poison <= 1'b0;
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            run    <= 1'b1;
            poison <= in_x;
            // The edge that synchronizes RN release never grants, and an
            // edge with unknown inputs leaves the state untouched.
            if (run && !in_x) begin
                state  <= nxt_state;
                cnt    <= nxt_cnt;
                last   <= nxt_last;
                gnt0_q <= (nxt_state == G0);
                gnt1_q <= (nxt_state == G1);
                busy_q <= (nxt_state == G0) || (nxt_state == G1);
            end
        end
    end

    assign GNT0 = (poison || viol) ? 1'bx : gnt0_q;
    assign GNT1 = (poison || viol) ? 1'bx : gnt1_q;
    assign BUSY = (poison || viol) ? 1'bx : busy_q;

`ifdef GF180_TIMING
    reg notifier;

    // Any notifier toggle poisons the outputs; only reset clears it.
    always @(notifier or negedge RN) begin
        if (!RN) viol = 1'b0;
        else     viol = 1'b1;
    end

    specify
        (posedge CLK => (GNT0 +: 1'b1)) = (0, 0);
        (posedge CLK => (GNT1 +: 1'b1)) = (0, 0);
        (posedge CLK => (BUSY +: 1'b1)) = (0, 0);
        (negedge RN  => (GNT0 +: 1'b0)) = (0, 0);
        (negedge RN  => (GNT1 +: 1'b0)) = (0, 0);
        (negedge RN  => (BUSY +: 1'b0)) = (0, 0);
        $setup(REQ0, posedge CLK, 0, notifier);
        $setup(REQ1, posedge CLK, 0, notifier);
        $setup(LOCK, posedge CLK, 0, notifier);
        $hold(posedge CLK, REQ0, 0, notifier);
        $hold(posedge CLK, REQ1, 0, notifier);
        $hold(posedge CLK, LOCK, 0, notifier);
        $recovery(posedge RN, posedge CLK, 0, notifier);
    endspecify
`else
    assign viol = 1'b0;
`endif

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__rrarb2_1.sv
// ---------------------------------------------------------------------------
// Directed bench for the two-requester round-robin arbiter cell.
// dut_a uses HOLD_MAX=4, dut_b uses HOLD_MAX=1; both share the stimulus.
// Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_gf180mcu_osu_sc_gp9t3v3__rrarb2_1;

    logic CLK = 1'b0;
    logic RN, REQ0, REQ1, LOCK;
    logic a_gnt0, a_gnt1, a_busy;
    logic b_gnt0, b_gnt1, b_busy;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    gf180mcu_osu_sc_gp9t3v3__rrarb2_1 #(.HOLD_MAX(4)) dut_a (
        .CLK (CLK), .RN (RN), .REQ0 (REQ0), .REQ1 (REQ1), .LOCK (LOCK),
        .GNT0(a_gnt0), .GNT1(a_gnt1), .BUSY(a_busy)
    );

    gf180mcu_osu_sc_gp9t3v3__rrarb2_1 #(.HOLD_MAX(1)) dut_b (
        .CLK (CLK), .RN (RN), .REQ0 (REQ0), .REQ1 (REQ1), .LOCK (LOCK),
        .GNT0(b_gnt0), .GNT1(b_gnt1), .BUSY(b_busy)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic exp_a(input string tag, input logic e0, input logic e1);
        chk({tag, ".a.gnt0"}, a_gnt0, e0);
        chk({tag, ".a.gnt1"}, a_gnt1, e1);
        chk({tag, ".a.busy"}, a_busy, e0 | e1);
        chk({tag, ".a.excl"}, a_gnt0 & a_gnt1, 1'b0);
    endtask

    task automatic exp_b(input string tag, input logic e0, input logic e1);
        chk({tag, ".b.gnt0"}, b_gnt0, e0);
        chk({tag, ".b.gnt1"}, b_gnt1, e1);
        chk({tag, ".b.busy"}, b_busy, e0 | e1);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RN = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; LOCK = 1'b0;
        step();
        step();
        exp_a("reset", 1'b0, 1'b0);
        exp_b("reset", 1'b0, 1'b0);

        // Both request from reset: sync edge, then G0 x4, dead, G1 x4, dead, G0
        RN = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1;
        step();
        exp_a("sync1", 1'b0, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            step();
            exp_a($sformatf("rr_c%0d", c), (c <= 4) || (c == 11), (c >= 6) && (c <= 9));
        end

        // Back to idle, then REQ1 alone for three sampled edges
        REQ0 = 1'b0; REQ1 = 1'b0;
        step();
        exp_a("idle1", 1'b0, 1'b0);
        REQ1 = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            exp_a($sformatf("solo1_c%0d", c), 1'b0, 1'b1);
        end
        REQ1 = 1'b0;
        step();
        exp_a("solo1_rel", 1'b0, 1'b0);
        REQ0 = 1'b1; REQ1 = 1'b1;   // tie after source 1 owned last
        step();
        exp_a("tie_last1", 1'b1, 1'b0);
        REQ0 = 1'b0; REQ1 = 1'b0;
        step();
        exp_a("idle2", 1'b0, 1'b0);

        // LOCK holds G0 against a waiting REQ1 well past HOLD_MAX
        REQ0 = 1'b1; LOCK = 1'b1;
        step();
        exp_a("lock_entry", 1'b1, 1'b0);
        REQ1 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_a($sformatf("lock_c%0d", c), 1'b1, 1'b0);
        end
        LOCK = 1'b0;
        step();
        exp_a("unlock_dead", 1'b0, 1'b0);
        step();
        exp_a("unlock_g1", 1'b0, 1'b1);

        // In G1, REQ1 drops while REQ0 waits: one dead cycle then G0
        REQ1 = 1'b0;
        step();
        exp_a("rel_dead", 1'b0, 1'b0);
        step();
        exp_a("rel_g0", 1'b1, 1'b0);

        // Asynchronous reset between edges while in G0
        #2;
        RN = 1'b0;
        #1;
        exp_a("rst_async", 1'b0, 1'b0);
        REQ0 = 1'b0; REQ1 = 1'b1;
        step();
        exp_a("rst_held", 1'b0, 1'b0);
        RN = 1'b1;
        step();
        exp_a("recovery", 1'b0, 1'b0);
        step();
        exp_a("post_rst", 1'b0, 1'b1);

        // Fresh reset, both held: dut_b (HOLD_MAX=1) cycles every 4
        RN = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
        step();
        RN = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1;
        step();
        exp_b("sync2", 1'b0, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            step();
            exp_b($sformatf("h1_c%0d", c), (c % 4) == 1, (c % 4) == 3);
            exp_a($sformatf("h4_c%0d", c), c <= 4, c >= 6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
